// File: rtl/npc_ctrl_pkg.sv
// rtl/npc_ctrl_pkg.sv - shared control types for the NPC sequencer and decoder
package npc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT,
    ST_TRAP
  } seq_state_e;

  localparam int MICRO_W      = 14;
  localparam int MC_REGEN     = 13;
  localparam int MC_PCJEN     = 12;
  localparam int MC_PCREN     = 11;
  localparam int MC_MWEN_HI   = 10;
  localparam int MC_MWEN_LO   = 9;
  localparam int MC_MREN_HI   = 8;
  localparam int MC_MREN_LO   = 7;
  localparam int MC_ALUOP_HI  = 6;
  localparam int MC_ALUOP_LO  = 4;
  localparam int MC_UNSIGN    = 3;
  localparam int MC_IMM_HI    = 2;
  localparam int MC_IMM_LO    = 0;

  localparam logic [1:0] MEM_NONE = 2'b00;
  localparam logic [1:0] MEM_B    = 2'b01;
  localparam logic [1:0] MEM_H    = 2'b10;
  localparam logic [1:0] MEM_W    = 2'b11;

  localparam logic [2:0] IMM_NONE = 3'b000;
  localparam logic [2:0] IMM_I    = 3'b001;
  localparam logic [2:0] IMM_S    = 3'b010;
  localparam logic [2:0] IMM_SB   = 3'b011;
  localparam logic [2:0] IMM_U    = 3'b100;
  localparam logic [2:0] IMM_UJ   = 3'b101;

  typedef struct packed {
    logic       regen;
    logic       pcjen;
    logic       pcren;
    logic [1:0] mwen;
    logic [1:0] mren;
    logic [2:0] aluop;
    logic       unsign;
    logic [2:0] imm_type;
  } micro_cmd_t;

  function automatic logic [1:0] mem_size(input micro_cmd_t mc);
    return (mc.mwen != MEM_NONE) ? mc.mwen : mc.mren;
  endfunction

endpackage

// File: rtl/npc_pc_next.sv
// rtl/npc_pc_next.sv - combinational next-PC select with misalignment flag
module npc_pc_next
  import npc_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] jump_target,
  input  logic            br_cond,
  input  logic            pcjen,
  input  logic [2:0]      imm_type,
  output logic [XLEN-1:0] pc_next,
  output logic            misaligned
);

  logic [XLEN-1:0] pc_plus4;

  assign pc_plus4 = pc + XLEN'(4);

  always_comb begin
    pc_next = pc_plus4;
    if (pcjen) begin
      if (imm_type == IMM_SB) begin
        pc_next = br_cond ? jump_target : pc_plus4;
      end else begin
        // JALR semantics: bit 0 of the computed target is always dropped
        pc_next = {jump_target[XLEN-1:1], 1'b0};
      end
    end
  end

  assign misaligned = (pc_next[1:0] != 2'b00);

endmodule

// File: rtl/npc_inst_sequencer.sv
// rtl/npc_inst_sequencer.sv - multi-cycle fetch/decode/exec/mem/wb control FSM
// Optional perf counters enabled by defining NPC_SEQ_PERF_EN.
module npc_inst_sequencer
  import npc_ctrl_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h8000_0000,
  parameter int              MICRO_LEN = 14
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 imem_req,
  output logic [XLEN-1:0]      imem_addr,
  input  logic                 imem_rvalid,
  input  logic [31:0]          imem_rdata,
  output logic [31:0]          inst,
  input  logic [MICRO_LEN-1:0] micro_cmd,
  input  logic                 dec_hit,
  input  logic                 br_cond,
  input  logic [XLEN-1:0]      jump_target,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [1:0]           dmem_size,
  input  logic                 dmem_ack,
  output logic                 rf_wen,
  output logic [XLEN-1:0]      pc,
  output logic                 retire,
  output logic                 halted,
  output logic                 illegal
`ifdef NPC_SEQ_PERF_EN
  ,
  output logic [63:0]          perf_cycle,
  output logic [63:0]          perf_instret
`endif
);

  seq_state_e      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     inst_q, inst_d;
  logic            imem_req_q, imem_req_d;
  logic            dmem_req_q, dmem_req_d;
  logic            dmem_we_q, dmem_we_d;
  logic [1:0]      dmem_size_q, dmem_size_d;
  logic            rf_wen_q, rf_wen_d;
  logic            retire_q, retire_d;
  logic            halted_q, halted_d;
  logic            illegal_q, illegal_d;

  micro_cmd_t      mc;
  logic            mem_rd, mem_wr;
  logic [XLEN-1:0] pc_next;
  logic            pc_misaligned;
  logic            fetch_ok;
  logic            unused_mc;

  assign mc        = micro_cmd_t'(micro_cmd);
  assign mem_rd    = (mc.mren != MEM_NONE);
  assign mem_wr    = (mc.mwen != MEM_NONE);
  assign unused_mc = ^{mc.pcren, mc.aluop, mc.unsign};

  npc_pc_next #(.XLEN(XLEN)) u_pc_next (
    .pc          (pc_q),
    .jump_target (jump_target),
    .br_cond     (br_cond),
    .pcjen       (mc.pcjen),
    .imm_type    (mc.imm_type),
    .pc_next     (pc_next),
    .misaligned  (pc_misaligned)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    case (state_q)
      ST_FETCH: begin
        if (pc_q[1:0] != 2'b00) begin
          state_d = ST_TRAP;
        end else if (imem_req_q && imem_rvalid) begin
          inst_d  = imem_rdata;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (!dec_hit)                state_d = ST_TRAP;
        else if (micro_cmd == '0)    state_d = ST_HALT;
        else if (mem_rd && mem_wr)   state_d = ST_TRAP;
        else                         state_d = ST_EXEC;
      end
      ST_EXEC:  state_d = (mem_rd || mem_wr) ? ST_MEM : ST_WB;
      ST_MEM:   if (dmem_ack) state_d = ST_WB;
      ST_WB: begin
        pc_d    = pc_next;
        state_d = ST_FETCH;
      end
      ST_HALT:  state_d = ST_HALT;
      ST_TRAP:  state_d = ST_TRAP;
      default:  state_d = ST_TRAP;
    endcase
  end

  // Outputs are registered from the next state, so the first cycle after reset
  // sits in FETCH with the request still low; the request rises one cycle later.
  always_comb begin
    fetch_ok    = (state_q == ST_WB) ? !pc_misaligned : (pc_q[1:0] == 2'b00);
    imem_req_d  = (state_d == ST_FETCH) && fetch_ok;
    dmem_req_d  = (state_d == ST_MEM);
    dmem_we_d   = (state_d == ST_MEM) && mem_wr;
    dmem_size_d = (state_d == ST_MEM) ? mem_size(mc) : 2'b00;
    rf_wen_d    = (state_d == ST_WB) && mc.regen;
    retire_d    = (state_d == ST_WB);
    halted_d    = (state_d == ST_HALT);
    illegal_d   = (state_d == ST_TRAP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FETCH;
      pc_q        <= RESET_PC;
      inst_q      <= '0;
      imem_req_q  <= 1'b0;
      dmem_req_q  <= 1'b0;
      dmem_we_q   <= 1'b0;
      dmem_size_q <= 2'b00;
      rf_wen_q    <= 1'b0;
      retire_q    <= 1'b0;
      halted_q    <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      imem_req_q  <= imem_req_d;
      dmem_req_q  <= dmem_req_d;
      dmem_we_q   <= dmem_we_d;
      dmem_size_q <= dmem_size_d;
      rf_wen_q    <= rf_wen_d;
      retire_q    <= retire_d;
      halted_q    <= halted_d;
      illegal_q   <= illegal_d;
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = pc_q;
  assign inst      = inst_q;
  assign dmem_req  = dmem_req_q;
  assign dmem_we   = dmem_we_q;
  assign dmem_size = dmem_size_q;
  assign rf_wen    = rf_wen_q;
  assign pc        = pc_q;
  assign retire    = retire_q;
  assign halted    = halted_q;
  assign illegal   = illegal_q;

`ifdef NPC_SEQ_PERF_EN
  logic [63:0] perf_cycle_q, perf_cycle_d;
  logic [63:0] perf_instret_q, perf_instret_d;

  always_comb begin
    perf_cycle_d   = perf_cycle_q;
    perf_instret_d = perf_instret_q;
    if (state_q != ST_HALT && state_q != ST_TRAP) perf_cycle_d = perf_cycle_q + 64'd1;
    if (retire_q) perf_instret_d = perf_instret_q + 64'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycle_q   <= '0;
      perf_instret_q <= '0;
    end else begin
      perf_cycle_q   <= perf_cycle_d;
      perf_instret_q <= perf_instret_d;
    end
  end

  assign perf_cycle   = perf_cycle_q;
  assign perf_instret = perf_instret_q;
`endif

endmodule

// File: tb/tb_npc_inst_sequencer.sv
// tb/tb_npc_inst_sequencer.sv - randomized self-checking bench for npc_inst_sequencer
module tb_npc_inst_sequencer;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [13:0] micro_cmd;
  logic        dec_hit;
  logic        br_cond;
  logic [31:0] jump_target;
  logic        dmem_req;
  logic        dmem_we;
  logic [1:0]  dmem_size;
  logic        dmem_ack;
  logic        rf_wen;
  logic [31:0] pc;
  logic        retire;
  logic        halted;
  logic        illegal;
`ifdef NPC_SEQ_PERF_EN
  logic [63:0] perf_cycle;
  logic [63:0] perf_instret;
`endif

  npc_inst_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst        (inst),
    .micro_cmd   (micro_cmd),
    .dec_hit     (dec_hit),
    .br_cond     (br_cond),
    .jump_target (jump_target),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_size   (dmem_size),
    .dmem_ack    (dmem_ack),
    .rf_wen      (rf_wen),
    .pc          (pc),
    .retire      (retire),
    .halted      (halted),
    .illegal     (illegal)
`ifdef NPC_SEQ_PERF_EN
    ,
    .perf_cycle  (perf_cycle),
    .perf_instret(perf_instret)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic [13:0] micro;
    logic        hit;
    logic        br;
    logic [31:0] jt;
    int          idly;
    int          ddly;
  } ins_t;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_pc;
  int          exp_instret;

  function automatic logic [13:0] mk(input logic regen, input logic pcjen,
                                     input logic [1:0] mw, input logic [1:0] mr,
                                     input logic [2:0] imm);
    return {regen, pcjen, 1'b0, mw, mr, 3'b001, 1'b0, imm};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; micro_cmd = '0; dec_hit = 1'b0;
    br_cond = 1'b0; jump_target = '0; dmem_ack = 1'b0;
    repeat (3) @(negedge clk);
    exp_pc = RESET_PC;
    exp_instret = 0;
    rst_n = 1'b1;
  endtask

  task automatic run_inst(input ins_t t, input string name);
    int cyc, body, rf_cnt, ret_cnt, mreq_cnt, mwait, exp_body;
    logic we_ok, size_ok, exp_halt, exp_trap, exp_mem, exp_mis, exp_ret;
    logic [1:0] mw, mr, exp_size;
    logic [31:0] npc;
    mw = t.micro[10:9];
    mr = t.micro[8:7];
    exp_halt = t.hit && (t.micro == 14'h0);
    exp_trap = !t.hit || (!exp_halt && mw != 2'b00 && mr != 2'b00);
    exp_mem  = !exp_halt && !exp_trap && (mw != 2'b00 || mr != 2'b00);
    exp_ret  = !exp_halt && !exp_trap;
    exp_size = (mw != 2'b00) ? mw : mr;
    if (t.micro[12]) begin
      if (t.micro[2:0] == 3'b011) npc = t.br ? t.jt : exp_pc + 32'd4;
      else                        npc = t.jt & 32'hFFFF_FFFE;
    end else begin
      npc = exp_pc + 32'd4;
    end
    exp_mis  = exp_ret && (npc[1:0] != 2'b00);
    exp_body = exp_ret ? (3 + (exp_mem ? t.ddly + 1 : 0) + (exp_mis ? 1 : 0)) : 1;

    micro_cmd = t.micro; dec_hit = t.hit; br_cond = t.br; jump_target = t.jt;
    cyc = 0;
    while (imem_req !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (imem_req !== 1'b1) $display("FAIL %s fetch_req got %b want 1", name, imem_req);
    else n_pass++;
    n_checks++;
    if (imem_addr !== exp_pc) $display("FAIL %s imem_addr got %h want %h", name, imem_addr, exp_pc);
    else n_pass++;
    repeat (t.idly) @(negedge clk);
    imem_rvalid = 1'b1; imem_rdata = t.word;
    @(negedge clk);
    imem_rvalid = 1'b0; imem_rdata = $urandom;
    n_checks++;
    if (inst !== t.word) $display("FAIL %s inst got %h want %h", name, inst, t.word);
    else n_pass++;

    body = 0; rf_cnt = 0; ret_cnt = 0; mreq_cnt = 0; mwait = 0; we_ok = 1'b1; size_ok = 1'b1;
    while (body < 60 && imem_req !== 1'b1 && halted !== 1'b1 && illegal !== 1'b1) begin
      dmem_ack = 1'b0;
      if (rf_wen === 1'b1) rf_cnt++;
      if (retire === 1'b1) ret_cnt++;
      if (dmem_req === 1'b1) begin
        mreq_cnt++;
        if (dmem_we !== (mw != 2'b00)) we_ok = 1'b0;
        if (dmem_size !== exp_size) size_ok = 1'b0;
        if (mwait == t.ddly) dmem_ack = 1'b1;
        else mwait++;
      end
      body++;
      @(negedge clk);
    end
    dmem_ack = 1'b0;

    n_checks++;
    if (body != exp_body) $display("FAIL %s latency got %0d want %0d", name, body, exp_body);
    else n_pass++;
    n_checks++;
    if (ret_cnt != (exp_ret ? 1 : 0)) $display("FAIL %s retire got %0d want %0d", name, ret_cnt, exp_ret);
    else n_pass++;
    n_checks++;
    if (rf_cnt != ((exp_ret && t.micro[13]) ? 1 : 0))
      $display("FAIL %s rf_wen got %0d want %0d", name, rf_cnt, exp_ret && t.micro[13]);
    else n_pass++;
    n_checks++;
    if (mreq_cnt != (exp_mem ? t.ddly + 1 : 0) || !we_ok || !size_ok)
      $display("FAIL %s dmem got req=%0d we_ok=%b size_ok=%b want req=%0d", name, mreq_cnt, we_ok, size_ok,
               exp_mem ? t.ddly + 1 : 0);
    else n_pass++;
    n_checks++;
    if (halted !== exp_halt || illegal !== (exp_trap || exp_mis))
      $display("FAIL %s flags got h=%b i=%b want h=%b i=%b", name, halted, illegal, exp_halt, exp_trap || exp_mis);
    else n_pass++;
    if (exp_ret) begin
      exp_pc = npc;
      exp_instret++;
    end
    n_checks++;
    if (pc !== exp_pc) $display("FAIL %s pc got %h want %h", name, pc, exp_pc);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (imem_req !== 1'b0 || imem_addr !== RESET_PC || pc !== RESET_PC || inst !== 32'h0 ||
        dmem_req !== 1'b0 || dmem_we !== 1'b0 || dmem_size !== 2'b00 || rf_wen !== 1'b0 ||
        retire !== 1'b0 || halted !== 1'b0 || illegal !== 1'b0)
      $display("FAIL reset_state got req=%b addr=%h pc=%h inst=%h dreq=%b rf=%b ret=%b h=%b i=%b want all 0 addr=pc=%h",
               imem_req, imem_addr, pc, inst, dmem_req, rf_wen, retire, halted, illegal, RESET_PC);
    else n_pass++;
    do_reset();
  endtask

  task automatic test_addi();
    ins_t t;
    do_reset();
    t = '{word: 32'h0050_0093, micro: mk(1'b1, 1'b0, 2'b00, 2'b00, 3'b001), hit: 1'b1, br: 1'b0,
          jt: 32'h0, idly: 0, ddly: 0};
    run_inst(t, "addi");
  endtask

  task automatic test_store();
    ins_t t;
    t = '{word: 32'h0011_2023, micro: mk(1'b0, 1'b0, 2'b11, 2'b00, 3'b010), hit: 1'b1, br: 1'b0,
          jt: 32'h0, idly: 1, ddly: 2};
    run_inst(t, "sw");
  endtask

  task automatic test_branch();
    ins_t t;
    do_reset();
    t = '{word: 32'h0050_0093, micro: mk(1'b1, 1'b0, 2'b00, 2'b00, 3'b001), hit: 1'b1, br: 1'b0,
          jt: 32'h0, idly: 0, ddly: 0};
    run_inst(t, "addi_pre");
    t = '{word: 32'h0000_8663, micro: mk(1'b0, 1'b1, 2'b00, 2'b00, 3'b011), hit: 1'b1, br: 1'b1,
          jt: 32'h8000_0010, idly: 0, ddly: 0};
    run_inst(t, "beq_taken");
    t.br = 1'b0; t.jt = 32'h8000_0040;
    run_inst(t, "beq_not_taken");
    n_checks++;
    if (pc !== 32'h8000_0014) $display("FAIL beq_final_pc got %h want 80000014", pc);
    else n_pass++;
  endtask

  task automatic test_jump();
    ins_t t;
    t = '{word: 32'h0000_80e7, micro: mk(1'b1, 1'b1, 2'b00, 2'b00, 3'b001), hit: 1'b1, br: 1'b0,
          jt: 32'h8000_0101, idly: 0, ddly: 0};
    run_inst(t, "jalr");
    t = '{word: 32'h0000_00ef, micro: mk(1'b1, 1'b1, 2'b00, 2'b00, 3'b101), hit: 1'b1, br: 1'b0,
          jt: 32'hFFFF_FFFC, idly: 0, ddly: 0};
    run_inst(t, "jal_top");
    t = '{word: 32'h0050_0093, micro: mk(1'b1, 1'b0, 2'b00, 2'b00, 3'b001), hit: 1'b1, br: 1'b0,
          jt: 32'h0, idly: 2, ddly: 0};
    run_inst(t, "pc_wrap");
  endtask

  task automatic test_ebreak();
    ins_t t;
    int reqs, rets;
    logic [31:0] inst_hold;
    do_reset();
    t = '{word: 32'h0010_0073, micro: 14'h0, hit: 1'b1, br: 1'b0, jt: 32'h0, idly: 0, ddly: 0};
    run_inst(t, "ebreak");
    inst_hold = inst;
    reqs = 0; rets = 0;
    for (int i = 0; i < 20; i++) begin
      imem_rvalid = i[0]; imem_rdata = $urandom; dmem_ack = i[1];
      @(negedge clk);
      if (imem_req === 1'b1) reqs++;
      if (retire === 1'b1 || rf_wen === 1'b1 || dmem_req === 1'b1) rets++;
    end
    imem_rvalid = 1'b0; dmem_ack = 1'b0;
    n_checks++;
    if (reqs != 0 || rets != 0 || halted !== 1'b1 || illegal !== 1'b0 || inst !== inst_hold)
      $display("FAIL halt_absorb got reqs=%0d acts=%0d h=%b i=%b want 0 0 1 0", reqs, rets, halted, illegal);
    else n_pass++;
  endtask

  task automatic test_illegal();
    ins_t t;
    do_reset();
    t = '{word: 32'hFFFF_FFFF, micro: mk(1'b1, 1'b0, 2'b00, 2'b00, 3'b001), hit: 1'b0, br: 1'b0,
          jt: 32'h0, idly: 0, ddly: 0};
    run_inst(t, "decode_miss");
    do_reset();
    t = '{word: 32'h1234_5678, micro: mk(1'b1, 1'b0, 2'b10, 2'b01, 3'b001), hit: 1'b1, br: 1'b0,
          jt: 32'h0, idly: 0, ddly: 0};
    run_inst(t, "mren_mwen");
    do_reset();
    t = '{word: 32'h0000_00ef, micro: mk(1'b1, 1'b1, 2'b00, 2'b00, 3'b101), hit: 1'b1, br: 1'b0,
          jt: 32'h8000_0102, idly: 0, ddly: 0};
    run_inst(t, "misaligned");
  endtask

  task automatic test_reset_mid_mem();
    int cyc;
    do_reset();
    micro_cmd = mk(1'b1, 1'b0, 2'b00, 2'b11, 3'b001); dec_hit = 1'b1;
    cyc = 0;
    while (imem_req !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_a083;
    @(negedge clk);
    imem_rvalid = 1'b0;
    cyc = 0;
    while (dmem_req !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
    n_checks++;
    if (dmem_req !== 1'b1) $display("FAIL mid_mem_req got %b want 1", dmem_req);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (dmem_req !== 1'b0 || pc !== RESET_PC || imem_req !== 1'b0)
      $display("FAIL mid_mem_reset got dreq=%b pc=%h ireq=%b want 0 %h 0", dmem_req, pc, imem_req, RESET_PC);
    else n_pass++;
`ifdef NPC_SEQ_PERF_EN
    n_checks++;
    if (perf_cycle !== 64'd0 || perf_instret !== 64'd0)
      $display("FAIL perf_reset got %0d %0d want 0 0", perf_cycle, perf_instret);
    else n_pass++;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    exp_pc = RESET_PC;
    exp_instret = 0;
    dmem_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC || dmem_req !== 1'b0 || retire !== 1'b0)
      $display("FAIL late_ack got ireq=%b addr=%h dreq=%b ret=%b want 1 %h 0 0",
               imem_req, imem_addr, dmem_req, retire, RESET_PC);
    else n_pass++;
    dmem_ack = 1'b0;
    run_inst('{word: 32'h0050_0093, micro: mk(1'b1, 1'b0, 2'b00, 2'b00, 3'b001), hit: 1'b1,
               br: 1'b0, jt: 32'h0, idly: 0, ddly: 0}, "after_reset");
  endtask

  task automatic test_random();
    ins_t t;
    int k;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 5);
      t.word = $urandom;
      t.hit  = 1'b1;
      t.br   = 1'($urandom_range(0, 1));
      t.jt   = $urandom & 32'hFFFF_FFFC;
      t.idly = $urandom_range(0, 3);
      t.ddly = $urandom_range(0, 3);
      case (k)
        0: t.micro = mk(1'b1, 1'b0, 2'b00, 2'b00, 3'b001);
        1: t.micro = mk(1'b1, 1'b0, 2'b00, 2'($urandom_range(1, 3)), 3'b001);
        2: t.micro = mk(1'b0, 1'b0, 2'($urandom_range(1, 3)), 2'b00, 3'b010);
        3: t.micro = mk(1'b0, 1'b1, 2'b00, 2'b00, 3'b011);
        4: t.micro = mk(1'b1, 1'b1, 2'b00, 2'b00, 3'b101);
        default: begin
          t.micro = mk(1'b1, 1'b1, 2'b00, 2'b00, 3'b001);
          t.jt    = t.jt | 32'($urandom_range(0, 1));
        end
      endcase
      run_inst(t, "random");
    end
`ifdef NPC_SEQ_PERF_EN
    n_checks++;
    if (perf_instret !== 64'(exp_instret))
      $display("FAIL perf_instret got %0d want %0d", perf_instret, exp_instret);
    else n_pass++;
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; micro_cmd = '0; dec_hit = 1'b0;
    br_cond = 1'b0; jump_target = '0; dmem_ack = 1'b0;
    exp_pc = RESET_PC;
    exp_instret = 0;
    @(negedge clk);
    test_reset();
    test_addi();
    test_store();
    test_branch();
    test_jump();
    test_ebreak();
    test_illegal();
    test_reset_mid_mem();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
